// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared forwarding select codes and Tnew constants for hazard_ctrl
package hazard_ctrl_pkg;

   localparam int HC_AW = 5;
   localparam int HC_TW = 2;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_E  = 2'd1,
      FWD_M  = 2'd2,
      FWD_W  = 2'd3
   } fwd_sel_t;

   localparam logic [HC_TW-1:0] TNEW_JAL  = 2'd0;
   localparam logic [HC_TW-1:0] TNEW_ALU  = 2'd1;
   localparam logic [HC_TW-1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/hazard_ctrl_stage_tag_reg.sv
// rtl/hazard_ctrl_stage_tag_reg.sv - one pipe stage of destination tag: a3/we/tnew
// DEC selects whether tnew counts down (saturating at 0) on entry to this stage.
module stage_tag_reg #(
   parameter int AW  = 5,
   parameter int TW  = 2,
   parameter bit DEC = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          bubble,
   input  logic [AW-1:0] src_a3,
   input  logic          src_we,
   input  logic [TW-1:0] src_tnew,
   output logic [AW-1:0] a3,
   output logic          we,
   output logic [TW-1:0] tnew
);

   logic [TW-1:0] tnew_nxt;

   always_comb begin
      tnew_nxt = src_tnew;
      if (DEC && (src_tnew != '0)) begin
         tnew_nxt = src_tnew - {{(TW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a3   <= '0;
         we   <= 1'b0;
         tnew <= '0;
      end else if (bubble) begin
         a3   <= '0;
         we   <= 1'b0;
         tnew <= '0;
      end else begin
         a3   <= src_a3;
         we   <= src_we;
         tnew <= tnew_nxt;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - D-stage stall and D/E operand forwarding selects for the MIPS pipe
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int AW = 5,
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] rs_d,
   input  logic [AW-1:0] rt_d,
   input  logic [TW-1:0] tuse_rs,
   input  logic [TW-1:0] tuse_rt,
   input  logic          use_rs,
   input  logic          use_rt,
   input  logic [AW-1:0] a3_d,
   input  logic          we_d,
   input  logic [TW-1:0] tnew_d,
   output logic          stall,
   output logic [1:0]    fwd_rs_d,
   output logic [1:0]    fwd_rt_d,
   output logic [1:0]    fwd_rs_e,
   output logic [1:0]    fwd_rt_e
);

   logic [AW-1:0] a3_e, a3_m, a3_w;
   logic          we_e, we_m, we_w;
   logic [TW-1:0] tnew_e, tnew_m, tnew_w;
   logic [AW-1:0] rs_e, rt_e;

   // E keeps tnew as issued; it counts down only on the way into M and W.
   stage_tag_reg #(.AW(AW), .TW(TW), .DEC(1'b0)) u_tag_e (
      .clk      (clk),
      .reset    (reset),
      .bubble   (stall),
      .src_a3   (a3_d),
      .src_we   (we_d),
      .src_tnew (tnew_d),
      .a3       (a3_e),
      .we       (we_e),
      .tnew     (tnew_e)
   );

   stage_tag_reg #(.AW(AW), .TW(TW), .DEC(1'b1)) u_tag_m (
      .clk      (clk),
      .reset    (reset),
      .bubble   (1'b0),
      .src_a3   (a3_e),
      .src_we   (we_e),
      .src_tnew (tnew_e),
      .a3       (a3_m),
      .we       (we_m),
      .tnew     (tnew_m)
   );

   stage_tag_reg #(.AW(AW), .TW(TW), .DEC(1'b1)) u_tag_w (
      .clk      (clk),
      .reset    (reset),
      .bubble   (1'b0),
      .src_a3   (a3_m),
      .src_we   (we_m),
      .src_tnew (tnew_m),
      .a3       (a3_w),
      .we       (we_w),
      .tnew     (tnew_w)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rs_e <= '0;
         rt_e <= '0;
      end else if (stall) begin
         rs_e <= '0;
         rt_e <= '0;
      end else begin
         rs_e <= rs_d;
         rt_e <= rt_d;
      end
   end

   function automatic logic hit(input logic we, input logic [AW-1:0] a3,
                                input logic [AW-1:0] r);
      return we && (a3 == r) && (r != '0);
   endfunction

   // The newest matching producer decides; if it is not ready it masks older ones.
   function automatic logic [1:0] fwd_d_sel(input logic he, input logic hm, input logic hw,
                                            input logic [TW-1:0] t_e,
                                            input logic [TW-1:0] t_m,
                                            input logic [TW-1:0] t_w);
      if (he)      return (t_e == '0) ? FWD_E : FWD_RF;
      else if (hm) return (t_m == '0) ? FWD_M : FWD_RF;
      else if (hw) return (t_w == '0) ? FWD_W : FWD_RF;
      return FWD_RF;
   endfunction

   function automatic logic [1:0] fwd_e_sel(input logic hm, input logic [TW-1:0] t_m,
                                            input logic hw);
      if (hm && (t_m == '0)) return FWD_M;
      else if (hw)           return FWD_W;
      return FWD_RF;
   endfunction

   logic hit_e_rs, hit_m_rs, hit_w_rs;
   logic hit_e_rt, hit_m_rt, hit_w_rt;
   logic hit_me_rs, hit_we_rs, hit_me_rt, hit_we_rt;
   logic stall_rs, stall_rt;

   assign hit_e_rs  = hit(we_e, a3_e, rs_d);
   assign hit_m_rs  = hit(we_m, a3_m, rs_d);
   assign hit_w_rs  = hit(we_w, a3_w, rs_d);
   assign hit_e_rt  = hit(we_e, a3_e, rt_d);
   assign hit_m_rt  = hit(we_m, a3_m, rt_d);
   assign hit_w_rt  = hit(we_w, a3_w, rt_d);
   assign hit_me_rs = hit(we_m, a3_m, rs_e);
   assign hit_we_rs = hit(we_w, a3_w, rs_e);
   assign hit_me_rt = hit(we_m, a3_m, rt_e);
   assign hit_we_rt = hit(we_w, a3_w, rt_e);

   assign stall_rs = use_rs && ((hit_e_rs && (tnew_e > tuse_rs)) ||
                                (hit_m_rs && (tnew_m > tuse_rs)));
   assign stall_rt = use_rt && ((hit_e_rt && (tnew_e > tuse_rt)) ||
                                (hit_m_rt && (tnew_m > tuse_rt)));
   assign stall    = stall_rs || stall_rt;

   assign fwd_rs_d = fwd_d_sel(hit_e_rs, hit_m_rs, hit_w_rs, tnew_e, tnew_m, tnew_w);
   assign fwd_rt_d = fwd_d_sel(hit_e_rt, hit_m_rt, hit_w_rt, tnew_e, tnew_m, tnew_w);
   assign fwd_rs_e = fwd_e_sel(hit_me_rs, tnew_m, hit_we_rs);
   assign fwd_rt_e = fwd_e_sel(hit_me_rt, tnew_m, hit_we_rt);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random checks of hazard_ctrl against an in-flight instruction model
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_d, rt_d, a3_d;
   logic [1:0] tuse_rs, tuse_rt, tnew_d;
   logic       use_rs, use_rt, we_d;
   logic       stall;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.AW(5), .TW(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .rs_d     (rs_d),
      .rt_d     (rt_d),
      .tuse_rs  (tuse_rs),
      .tuse_rt  (tuse_rt),
      .use_rs   (use_rs),
      .use_rt   (use_rt),
      .a3_d     (a3_d),
      .we_d     (we_d),
      .tnew_d   (tnew_d),
      .stall    (stall),
      .fwd_rs_d (fwd_rs_d),
      .fwd_rt_d (fwd_rt_d),
      .fwd_rs_e (fwd_rs_e),
      .fwd_rt_e (fwd_rt_e)
   );

   // In-flight instructions: slot 0 = E, 1 = M, 2 = W; tnew is cycles still to go.
   logic [4:0] m_a3 [3];
   logic [4:0] m_rs [3];
   logic [4:0] m_rt [3];
   logic       m_we [3];
   int         m_tn [3];

   function automatic bit mprod(int s, logic [4:0] r);
      return m_we[s] && (m_a3[s] == r) && (r != 5'd0);
   endfunction

   function automatic logic m_need(logic u, logic [4:0] r, logic [1:0] tu);
      if (!u) return 1'b0;
      for (int s = 0; s < 2; s++)
         if (mprod(s, r) && (m_tn[s] > int'(tu))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] m_fwd_d(logic [4:0] r);
      for (int s = 0; s < 3; s++)
         if (mprod(s, r)) return (m_tn[s] == 0) ? 2'(s + 1) : 2'd0;
      return 2'd0;
   endfunction

   function automatic logic [1:0] m_fwd_e(logic [4:0] r);
      if (mprod(1, r) && (m_tn[1] == 0)) return 2'd2;
      if (mprod(2, r)) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic m_stall();
      return m_need(use_rs, rs_d, tuse_rs) || m_need(use_rt, rt_d, tuse_rt);
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 3; s++) begin
         m_a3[s] = '0; m_rs[s] = '0; m_rt[s] = '0; m_we[s] = 1'b0; m_tn[s] = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk($sformatf("%s.stall", tag), {1'b0, stall}, {1'b0, m_stall()});
      chk($sformatf("%s.fwd_rs_d", tag), fwd_rs_d, m_fwd_d(rs_d));
      chk($sformatf("%s.fwd_rt_d", tag), fwd_rt_d, m_fwd_d(rt_d));
      chk($sformatf("%s.fwd_rs_e", tag), fwd_rs_e, m_fwd_e(m_rs[0]));
      chk($sformatf("%s.fwd_rt_e", tag), fwd_rt_e, m_fwd_e(m_rt[0]));
   endtask

   task automatic drive(input logic [4:0] a3, input logic we, input logic [1:0] tn,
                        input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                        input logic [4:0] rt, input logic urt, input logic [1:0] trt);
      a3_d = a3; we_d = we; tnew_d = tn;
      rs_d = rs; use_rs = urs; tuse_rs = trs;
      rt_d = rt; use_rt = urt; tuse_rt = trt;
   endtask

   task automatic nop();
      drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
   endtask

   // Advance one clock: older instructions age by a stage, D enters E unless stalled.
   task automatic tick();
      logic st;
      st = m_stall();
      @(posedge clk);
      for (int s = 2; s > 0; s--) begin
         m_a3[s] = m_a3[s-1]; m_we[s] = m_we[s-1];
         m_rs[s] = m_rs[s-1]; m_rt[s] = m_rt[s-1];
         m_tn[s] = (m_tn[s-1] > 0) ? m_tn[s-1] - 1 : 0;
      end
      if (st) begin
         m_a3[0] = '0; m_we[0] = 1'b0; m_tn[0] = 0; m_rs[0] = '0; m_rt[0] = '0;
      end else begin
         m_a3[0] = a3_d; m_we[0] = we_d; m_tn[0] = int'(tnew_d);
         m_rs[0] = rs_d; m_rt[0] = rt_d;
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      nop();
      model_clear();
      #2;
      chk("reset.stall", {1'b0, stall}, 2'd0);
      chk("reset.fwd_rs_d", fwd_rs_d, 2'd0);
      chk("reset.fwd_rs_e", fwd_rs_e, 2'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // ALU writes $8, beq reads $8 in D
      drive(5'd8, 1'b1, TNEW_ALU, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t1.prod"); tick();
      drive(5'd0, 1'b0, 2'd0, 5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t1.read0");
      chk("t1.stall_on", {1'b0, stall}, 2'd1);
      tick();
      #1 check_all("t1.read1");
      chk("t1.stall_off", {1'b0, stall}, 2'd0);
      chk("t1.fwd_m", fwd_rs_d, FWD_M);
      tick();

      // lw $9, addu reads $9 in E
      drive(5'd9, 1'b1, TNEW_LOAD, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t2.prod"); tick();
      drive(5'd10, 1'b1, TNEW_ALU, 5'd9, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0);
      #1 check_all("t2.read0");
      chk("t2.stall_on", {1'b0, stall}, 2'd1);
      tick();
      #1 check_all("t2.read1");
      chk("t2.stall_off", {1'b0, stall}, 2'd0);
      tick();
      nop();
      #1 check_all("t2.in_e");
      chk("t2.fwd_e_w", fwd_rs_e, FWD_W);
      tick();

      // jal then jr $31
      drive(5'd31, 1'b1, TNEW_JAL, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t3.jal"); tick();
      drive(5'd0, 1'b0, 2'd0, 5'd31, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t3.jr");
      chk("t3.stall", {1'b0, stall}, 2'd0);
      chk("t3.fwd_e", fwd_rs_d, FWD_E);
      tick();

      // writes to $0 never match
      for (int t = 0; t < 3; t++) begin
         drive(5'd0, 1'b1, 2'(t), 5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0);
         #1 check_all($sformatf("t4.w%0d", t));
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0);
         #1 check_all($sformatf("t4.r%0d", k));
         chk($sformatf("t4.stall%0d", k), {1'b0, stall}, 2'd0);
         chk($sformatf("t4.fwd%0d", k), fwd_rs_d | fwd_rt_d | fwd_rs_e | fwd_rt_e, 2'd0);
         tick();
      end

      // addu $5 then lw $5; newer not-ready producer masks the ready one
      drive(5'd5, 1'b1, TNEW_ALU, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t5.addu"); tick();
      drive(5'd5, 1'b1, TNEW_LOAD, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t5.lw"); tick();
      drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd0);
      #1 check_all("t5.r0");
      chk("t5.stall0", {1'b0, stall}, 2'd1);
      chk("t5.block0", fwd_rt_d, FWD_RF);
      tick();
      #1 check_all("t5.r1");
      chk("t5.block1", fwd_rt_d, FWD_RF);
      tick();
      #1 check_all("t5.r2");
      chk("t5.fwd_w", fwd_rt_d, FWD_W);
      tick();

      // async reset during the load-use stall
      drive(5'd9, 1'b1, TNEW_LOAD, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
      #1 check_all("t6.lw"); tick();
      drive(5'd10, 1'b1, TNEW_ALU, 5'd9, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0);
      #1 chk("t6.stall_on", {1'b0, stall}, 2'd1);
      #1 reset = 1'b0;
      #1 chk("t6.rst_stall", {1'b0, stall}, 2'd0);
      chk("t6.rst_fwd", fwd_rs_d | fwd_rt_d | fwd_rs_e | fwd_rt_e, 2'd0);
      model_clear();
      @(posedge clk);
      #2 check_all("t6.held");
      reset = 1'b1;
      #1 check_all("t6.empty");
      tick();
      #1 check_all("t6.after");
      tick();

      // random traffic on a small register set to force frequent matches
      for (int c = 0; c < 600; c++) begin
         drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
         #1 check_all($sformatf("rnd%0d", c));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
